d_mem: RTL and testbench

Byte-addressable RISC-V data memory serving the CPU's MEM stage for loads and stores of all RV32I widths. Reads are combinational and return a sign- or zero-extended word. Writes are synchronous with byte-lane enables derived from the access type and the low address bits.

---
 rtl/common_params.sv | 40 ++++
 rtl/load_extend.sv | 27 ++
 rtl/d_mem.sv | 59 +++++
 tb/tb_d_mem.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/common_params.sv
// Shared widths, the load/store access-type encoding and the lane helpers
// used by the data memory.
package common_params;

  localparam int BITS  = 32;
  localparam int ADDRW = 32;

  typedef enum logic [2:0] {
    WORD      = 3'd0,
    HALFWORD  = 3'd1,
    UHALFWORD = 3'd2,
    BYTE      = 3'd3,
    UBYTE     = 3'd4
  } mem_data_t;

  // Byte-lane enables for a store; codes outside the enum act as WORD.
  function automatic logic [3:0] lane_enables(input mem_data_t data_type,
                                              input logic [1:0] lane);
    logic [3:0] en;
    case (data_type)
      HALFWORD, UHALFWORD: en = lane[1] ? 4'b1100 : 4'b0011;
      BYTE, UBYTE:         en = 4'b0001 << lane;
      default:             en = 4'b1111;
    endcase
    return en;
  endfunction

  // Replicate right-aligned store data so every candidate lane sees it.
  function automatic logic [BITS-1:0] store_align(input mem_data_t data_type,
                                                  input logic [BITS-1:0] data);
    logic [BITS-1:0] aligned;
    case (data_type)
      HALFWORD, UHALFWORD: aligned = {2{data[15:0]}};
      BYTE, UBYTE:         aligned = {4{data[7:0]}};
      default:             aligned = data;
    endcase
    return aligned;
  endfunction

endpackage

// File: rtl/load_extend.sv
// Picks the addressed halfword/byte out of a stored word and sign- or
// zero-extends it to a full load result.
module load_extend
  import common_params::*;
(
  input  logic [BITS-1:0] word,
  input  logic [1:0]      lane,
  input  mem_data_t       data_type,
  output logic [BITS-1:0] data
);

  logic [15:0] half_val;
  logic [7:0]  byte_val;

  always_comb begin
    half_val = lane[1] ? word[31:16] : word[15:0];
    byte_val = word[8*lane +: 8];
    case (data_type)
      HALFWORD:  data = {{16{half_val[15]}}, half_val};
      UHALFWORD: data = {16'h0000, half_val};
      BYTE:      data = {{24{byte_val[7]}}, byte_val};
      UBYTE:     data = {24'h000000, byte_val};
      default:   data = word;
    endcase
  end

endmodule

// File: rtl/d_mem.sv
// Byte-addressable RV32I data memory: four byte lanes with asynchronous read
// and synchronous byte-enabled write. Upper address bits wrap.
module d_mem
  import common_params::*;
#(
  parameter int DEPTH_WORDS = 4096
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [ADDRW-1:0] MEM_ADDR,
  input  logic [BITS-1:0]  MEM_DATA_IN,
  input  logic             MEM_WRITE,
  input  logic             MEM_READ,
  input  mem_data_t        MEM_DATA_TYPE,
  output logic [BITS-1:0]  MEM_DATA_OUT
);

  localparam int IDXW = $clog2(DEPTH_WORDS);

  logic [IDXW-1:0] word_idx;
  logic [1:0]      lane;
  logic [3:0]      lane_en;
  logic [BITS-1:0] wr_word;
  logic [BITS-1:0] rd_word;
  logic [BITS-1:0] load_val;
  logic            wr_en;
  logic            unused_addr_hi;

  assign word_idx       = MEM_ADDR[IDXW+1:2];
  assign lane           = MEM_ADDR[1:0];
  assign unused_addr_hi = ^MEM_ADDR[ADDRW-1:IDXW+2];

  assign lane_en = lane_enables(MEM_DATA_TYPE, lane);
  assign wr_word = store_align(MEM_DATA_TYPE, MEM_DATA_IN);
  // Reset only gates stores; the array itself is never cleared by rst_n.
  assign wr_en   = MEM_WRITE & rst_n;

  for (genvar l = 0; l < 4; l++) begin : g_lane
    logic [7:0] mem [DEPTH_WORDS];

    always_ff @(posedge clk) begin
      if (wr_en && lane_en[l]) begin
        mem[word_idx] <= wr_word[8*l +: 8];
      end
    end

    assign rd_word[8*l +: 8] = mem[word_idx];
  end

  load_extend u_load_extend (
    .word      (rd_word),
    .lane      (lane),
    .data_type (MEM_DATA_TYPE),
    .data      (load_val)
  );

  assign MEM_DATA_OUT = (rst_n && MEM_READ) ? load_val : '0;

endmodule

// File: tb/tb_d_mem.sv
// Self-checking bench for d_mem: directed plan, vector table, reset sequence
// and randomized traffic against a byte-array reference model.
module tb_d_mem;
  import common_params::*;

  localparam int NBYTES = 4096 * 4;

  logic             clk;
  logic             rst_n;
  logic [ADDRW-1:0] MEM_ADDR;
  logic [BITS-1:0]  MEM_DATA_IN;
  logic             MEM_WRITE;
  logic             MEM_READ;
  mem_data_t        MEM_DATA_TYPE;
  logic [BITS-1:0]  MEM_DATA_OUT;

  int checks;
  int failures;

  logic [7:0] model_mem [NBYTES];

  d_mem #(.DEPTH_WORDS(4096)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .MEM_ADDR      (MEM_ADDR),
    .MEM_DATA_IN   (MEM_DATA_IN),
    .MEM_WRITE     (MEM_WRITE),
    .MEM_READ      (MEM_READ),
    .MEM_DATA_TYPE (MEM_DATA_TYPE),
    .MEM_DATA_OUT  (MEM_DATA_OUT)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [2:0]  wtype;
    logic        we;
    logic [2:0]  rtype;
    logic        re;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs [13];

  function automatic int access_bytes(input logic [2:0] code);
    if (code == 3'd1 || code == 3'd2) return 2;
    if (code == 3'd3 || code == 3'd4) return 1;
    return 4;
  endfunction

  function automatic logic [31:0] model_load(input logic [31:0] addr, input logic [2:0] code,
                                             input logic re);
    int n, base;
    longint v;
    if (!re) return 32'h0;
    n    = access_bytes(code);
    base = int'(addr % NBYTES);
    base = base - (base % n);
    v    = 0;
    for (int i = 0; i < n; i++) v = v + (longint'(model_mem[base + i]) << (8 * i));
    if (code == 3'd1 && v >= 32768) v = v - 65536;
    if (code == 3'd3 && v >= 128)   v = v - 256;
    return v[31:0];
  endfunction

  function automatic void model_store(input logic [31:0] addr, input logic [31:0] data,
                                      input logic [2:0] code);
    int n, base;
    n    = access_bytes(code);
    base = int'(addr % NBYTES);
    base = base - (base % n);
    for (int i = 0; i < n; i++) model_mem[base + i] = 8'((data >> (8 * i)) & 32'hFF);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_store(input logic [31:0] addr, input logic [31:0] data,
                          input logic [2:0] code);
    MEM_ADDR      = addr;
    MEM_DATA_IN   = data;
    MEM_DATA_TYPE = mem_data_t'(code);
    MEM_WRITE     = 1'b1;
    MEM_READ      = 1'b0;
    tick();
    MEM_WRITE     = 1'b0;
    model_store(addr, data, code);
  endtask

  task automatic do_load(input string name, input logic [31:0] addr, input logic [2:0] code,
                         input logic re, input logic [31:0] exp);
    MEM_ADDR      = addr;
    MEM_DATA_TYPE = mem_data_t'(code);
    MEM_READ      = re;
    #1;
    check(name, MEM_DATA_OUT, exp);
    MEM_READ      = 1'b0;
  endtask

  initial begin
    checks      = 0;
    failures    = 0;
    rst_n       = 1'b0;
    MEM_ADDR    = '0;
    MEM_DATA_IN = '0;
    MEM_WRITE   = 1'b0;
    MEM_READ    = 1'b1;
    MEM_DATA_TYPE = WORD;
    for (int i = 0; i < NBYTES; i++) model_mem[i] = 8'h00;

    #2;
    check("reset_out_zero", MEM_DATA_OUT, 32'h0);
    tick();
    rst_n    = 1'b1;
    MEM_READ = 1'b0;

    // Bring the whole array to a known all-zero state to match the model.
    for (int w = 0; w < 4096; w++) do_store(32'(w * 4), 32'h0, 3'd0);

    // Word plan
    for (int a = 0; a <= 396; a += 4) do_store(32'(a), 32'(a), 3'd0);
    for (int a = 0; a <= 396; a += 4) do_load("word_rd", 32'(a), 3'd0, 1'b1, 32'(a));

    // Halfword plan
    for (int a = 0; a <= 198; a += 2) do_store(32'(a), 32'(a) + 32'h8000, 3'd2);
    for (int a = 0; a <= 198; a += 2) do_load("uhalf_rd", 32'(a), 3'd2, 1'b1, 32'h0000_8000 + 32'(a));
    for (int a = 0; a <= 198; a += 2) do_load("half_rd", 32'(a), 3'd1, 1'b1, 32'hFFFF_8000 + 32'(a));

    // Byte plan
    for (int a = 0; a <= 99; a++) do_store(32'(a), 32'(a), 3'd4);
    for (int a = 0; a <= 99; a++) do_load("ubyte_rd", 32'(a), 3'd4, 1'b1, 32'(a));

    do_store(32'h101, 32'h80, 3'd3);
    do_store(32'h102, 32'h7F, 3'd3);
    do_load("sbyte_neg", 32'h101, 3'd3, 1'b1, 32'hFFFF_FF80);
    do_load("sbyte_pos", 32'h102, 3'd3, 1'b1, 32'h0000_007F);
    do_load("sbyte_neighbours", 32'h100, 3'd0, 1'b1, 32'h007F_8000);

    // Vector table
    vecs[0]  = '{32'h200,  32'h8765_4321, 3'd0, 1'b1, 3'd0, 1'b1, 32'h8765_4321};
    vecs[1]  = '{32'h202,  32'h0,         3'd0, 1'b0, 3'd1, 1'b1, 32'hFFFF_8765};
    vecs[2]  = '{32'h203,  32'h0,         3'd0, 1'b0, 3'd2, 1'b1, 32'h0000_8765};
    vecs[3]  = '{32'h200,  32'h0,         3'd0, 1'b0, 3'd3, 1'b1, 32'h0000_0021};
    vecs[4]  = '{32'h203,  32'h0,         3'd0, 1'b0, 3'd3, 1'b1, 32'hFFFF_FF87};
    vecs[5]  = '{32'h201,  32'h0,         3'd0, 1'b0, 3'd4, 1'b1, 32'h0000_0043};
    vecs[6]  = '{32'h201,  32'hFFFF_FFAA, 3'd3, 1'b1, 3'd0, 1'b1, 32'h8765_AA21};
    vecs[7]  = '{32'h203,  32'h1234_BEEF, 3'd2, 1'b1, 3'd0, 1'b1, 32'hBEEF_AA21};
    vecs[8]  = '{32'h200,  32'h0,         3'd0, 1'b0, 3'd5, 1'b1, 32'hBEEF_AA21};
    vecs[9]  = '{32'h202,  32'h0,         3'd0, 1'b0, 3'd7, 1'b1, 32'hBEEF_AA21};
    vecs[10] = '{32'h200,  32'h0,         3'd0, 1'b0, 3'd0, 1'b0, 32'h0000_0000};
    vecs[11] = '{32'h4200, 32'h0BAD_F00D, 3'd0, 1'b1, 3'd0, 1'b1, 32'h0BAD_F00D};
    vecs[12] = '{32'h200,  32'h0,         3'd0, 1'b0, 3'd1, 1'b1, 32'hFFFF_F00D};
    for (int i = 0; i < 13; i++) begin
      if (vecs[i].we) do_store(vecs[i].addr, vecs[i].wdata, vecs[i].wtype);
      do_load($sformatf("vec%0d", i), vecs[i].addr, vecs[i].rtype, vecs[i].re, vecs[i].exp);
    end

    // Read-during-write: old data until the edge, new data right after it
    MEM_ADDR      = 32'h204;
    MEM_DATA_IN   = 32'hCAFE_0001;
    MEM_DATA_TYPE = WORD;
    MEM_READ      = 1'b1;
    MEM_WRITE     = 1'b1;
    #1;
    check("rdw_pre_edge", MEM_DATA_OUT, 32'h0);
    tick();
    MEM_WRITE = 1'b0;
    model_store(32'h204, 32'hCAFE_0001, 3'd0);
    check("rdw_post_edge", MEM_DATA_OUT, 32'hCAFE_0001);
    MEM_READ = 1'b0;

    // Reset blocks stores and zeroes the output; contents survive release
    do_store(32'h300, 32'h5A5A_1234, 3'd0);
    MEM_ADDR      = 32'h300;
    MEM_DATA_IN   = 32'hDEAD_BEEF;
    MEM_DATA_TYPE = WORD;
    MEM_READ      = 1'b1;
    MEM_WRITE     = 1'b1;
    #1;
    check("rst_pre_assert", MEM_DATA_OUT, 32'h5A5A_1234);
    rst_n = 1'b0;
    #1;
    check("rst_out_zero", MEM_DATA_OUT, 32'h0);
    tick();
    check("rst_out_zero_edge", MEM_DATA_OUT, 32'h0);
    MEM_WRITE = 1'b0;
    rst_n     = 1'b1;
    #1;
    check("rst_data_kept", MEM_DATA_OUT, 32'h5A5A_1234);
    MEM_READ = 1'b0;

    // Randomized traffic against the model
    tick();
    for (int i = 0; i < 600; i++) begin
      logic [31:0] addr;
      logic [31:0] data;
      logic [2:0]  code;
      logic        we, re;
      addr = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 1023));
      data = $urandom;
      code = 3'($urandom_range(0, 7));
      we   = 1'($urandom_range(0, 1));
      re   = ($urandom_range(0, 7) != 0);
      MEM_ADDR      = addr;
      MEM_DATA_IN   = data;
      MEM_DATA_TYPE = mem_data_t'(code);
      MEM_WRITE     = we;
      MEM_READ      = re;
      #1;
      check("rand_rd", MEM_DATA_OUT, model_load(addr, code, re));
      @(posedge clk);
      #1;
      if (we) model_store(addr, data, code);
    end
    MEM_WRITE = 1'b0;
    MEM_READ  = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
